// File: rtl/divider_if.sv
// Request/result bundle for the iterative divider.
// master drives requests and out_rdy; slave is the divider.
interface divider_if #(
    parameter int DVD_W = 16,
    parameter int DVS_W = 8
);
    logic             div_vld;
    logic             div_rdy;
    logic [DVD_W-1:0] in0_data;
    logic [DVS_W-1:0] in1_data;
    logic             div_busy;
    logic             out_vld;
    logic             out_rdy;
    logic [DVD_W-1:0] out_quot;
    logic [DVS_W-1:0] out_rem;
    logic             out_dbz;

    modport master (
        output div_vld, in0_data, in1_data, out_rdy,
        input  div_rdy, div_busy, out_vld, out_quot, out_rem, out_dbz
    );

    modport slave (
        input  div_vld, in0_data, in1_data, out_rdy,
        output div_rdy, div_busy, out_vld, out_quot, out_rem, out_dbz
    );
endinterface

// File: rtl/divider.sv
// Restoring shift-subtract divider with request FIFO, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's-complement operands truncating toward zero.
module divider #(
    parameter int DVD_W      = 16,
    parameter int DVS_W      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input logic      clk,
    input logic      rst,
    divider_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DVD_W);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, FIXUP, DONE} state_t;

    logic [DVD_W+DVS_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wptr_q, rptr_q;
    logic [AW:0]            fcnt_q, fcnt_d;
    logic                   rdy_q, pushed_q;
    logic                   push, pop, avail;

    state_t           state_q, state_d;
    logic [DVD_W-1:0] dvd_q, dvd_d, q_q, q_d, quot_q, quot_d;
    logic [DVS_W-1:0] dvs_q, dvs_d, m_q, m_d, r_q, r_d, rem_q, rem_d;
    logic [DVS_W:0]   sh;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d, odbz_q, odbz_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;

    assign push   = bus.div_vld & rdy_q;
    // An entry written at the last edge is not yet visible to the FSM.
    assign avail  = fcnt_q > {{AW{1'b0}}, pushed_q};
    assign fcnt_d = fcnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {bus.in0_data, bus.in1_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            fcnt_q   <= '0;
            rdy_q    <= 1'b1;
            pushed_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            fcnt_q   <= fcnt_d;
            rdy_q    <= fcnt_d != (AW+1)'(FIFO_DEPTH);
            pushed_q <= push;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            odbz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            m_q     <= m_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            odbz_q  <= odbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        m_d     = m_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        odbz_d  = odbz_q;
        sh      = {r_q, q_q[DVD_W-1]};
        unique case (state_q)
            IDLE: begin
                if (avail) begin
                    pop            = 1'b1;
                    {dvd_d, dvs_d} = mem_q[rptr_q];
                    state_d        = LOAD;
                end
            end
            LOAD: begin
`ifdef DIV_SIGNED_EN
                qneg_d = dvd_q[DVD_W-1] ^ dvs_q[DVS_W-1];
                rneg_d = dvd_q[DVD_W-1];
                q_d    = dvd_q[DVD_W-1] ? -dvd_q : dvd_q;
                m_d    = dvs_q[DVS_W-1] ? -dvs_q : dvs_q;
`else
                qneg_d = 1'b0;
                rneg_d = 1'b0;
                q_d    = dvd_q;
                m_d    = dvs_q;
`endif
                r_d     = '0;
                cnt_d   = CW'(DVD_W - 1);
                dbz_d   = dvs_q == '0;
                state_d = (dvs_q == '0) ? FIXUP : CALC;
            end
            CALC: begin
                q_d = {q_q[DVD_W-2:0], 1'b0};
                if (sh >= {1'b0, m_q}) begin
                    r_d    = DVS_W'(sh - {1'b0, m_q});
                    q_d[0] = 1'b1;
                end else begin
                    r_d = sh[DVS_W-1:0];
                end
                if (cnt_q == '0) state_d = FIXUP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FIXUP: begin
                if (dbz_q) begin
                    quot_d = '1;
                    rem_d  = dvd_q[DVS_W-1:0];
                end else begin
                    quot_d = qneg_q ? -q_q : q_q;
                    rem_d  = rneg_q ? -r_q : r_q;
                end
                odbz_d  = dbz_q;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.div_rdy  = rdy_q;
    assign bus.div_busy = bus.div_vld | (fcnt_q != '0) | (state_q != IDLE);
    assign bus.out_vld  = state_q == DONE;
    assign bus.out_quot = quot_q;
    assign bus.out_rem  = rem_q;
    assign bus.out_dbz  = odbz_q;
endmodule

// File: tb/tb_divider.sv
// Randomised and directed checks of the divider against an arithmetic model.
// Signed cases are exercised when DIV_SIGNED_EN is defined.
module tb_divider;
    localparam int DVD_W = 16;
    localparam int DVS_W = 8;
    localparam int LAT   = DVD_W + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_res   = 0;
    logic mon_en  = 1'b0;
    logic last_hs = 1'b0;
    logic [DVD_W-1:0] last_q;
    logic [DVS_W-1:0] last_r;
    logic [DVD_W+DVS_W:0] exp_q[$];

    divider_if #(.DVD_W(DVD_W), .DVS_W(DVS_W)) bus ();

    divider #(.DVD_W(DVD_W), .DVS_W(DVS_W), .FIFO_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // {dbz, quotient, remainder} from plain integer arithmetic
    function automatic logic [DVD_W+DVS_W:0] model(
        input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b);
        logic [DVD_W-1:0] q;
        logic [DVS_W-1:0] r;
`ifdef DIV_SIGNED_EN
        int sa, sb;
`endif
        if (b == '0) return {1'b1, {DVD_W{1'b1}}, a[DVS_W-1:0]};
`ifdef DIV_SIGNED_EN
        sa = $signed(a);
        sb = $signed(b);
        q  = DVD_W'(sa / sb);
        r  = DVS_W'(sa % sb);
`else
        q  = a / DVD_W'(b);
        r  = DVS_W'(a % DVD_W'(b));
`endif
        return {1'b0, q, r};
    endfunction

    always @(negedge clk) begin
        if (mon_en && bus.out_vld && bus.out_rdy) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra", 1, 0);
            end else begin
                chk("sb_res", {bus.out_dbz, bus.out_quot, bus.out_rem},
                    exp_q.pop_front());
                n_res++;
                if (exp_q.size() == 0) begin
                    chk("t3_busy_hs", bus.div_busy, 1);
                    last_hs = 1'b1;
                end
            end
        end
    end

    // issue one request from idle, check latency and result, then handshake
    task automatic do_op(input logic [DVD_W-1:0] a,
                         input logic [DVS_W-1:0] b, input int lat_exp);
        int lat;
        logic [DVD_W+DVS_W:0] e;
        e = model(a, b);
        bus.in0_data = a;
        bus.in1_data = b;
        bus.div_vld  = 1'b1;
        @(posedge clk); #1;
        bus.div_vld = 1'b0;
        lat = 0;
        while (!bus.out_vld && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("op_lat", lat, lat_exp);
        chk("op_res", {bus.out_dbz, bus.out_quot, bus.out_rem}, e);
        last_q = bus.out_quot;
        last_r = bus.out_rem;
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;
        chk("op_vld_drop", bus.out_vld, 0);
    endtask

    initial begin
        logic [DVD_W-1:0] a, q0;
        logic [DVS_W-1:0] b, r0;
        logic [DVD_W+DVS_W:0] e;
        int lat, bad, acc, stale;
        logic saw_full;

        bus.div_vld  = 1'b0;
        bus.in0_data = '0;
        bus.in1_data = '0;
        bus.out_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_vld",  bus.out_vld, 0);
        chk("rst_rdy",  bus.div_rdy, 1);
        chk("rst_busy", bus.div_busy, 0);
        chk("rst_quot", bus.out_quot, 0);
        chk("rst_rem",  bus.out_rem, 0);
        chk("rst_dbz",  bus.out_dbz, 0);
        @(posedge clk); #1;

        do_op(16'd100, 8'd7, LAT);
`ifndef DIV_SIGNED_EN
        chk("t1_quot", last_q, 16'd14);
        chk("t1_rem",  last_r, 8'd2);
`endif
        do_op(16'd1234, 8'd0, 4);
        chk("t2_quot", last_q, 16'hFFFF);
        chk("t2_rem",  last_r, 8'hD2);

        for (int i = 0; i < 8; i++) begin
            a = DVD_W'($urandom);
            b = ($urandom_range(0, 5) == 0) ? '0 : DVS_W'($urandom);
            do_op(a, b, (b == '0) ? 4 : LAT);
        end

`ifdef DIV_SIGNED_EN
        do_op(-16'sd100, 8'd7, LAT);
        chk("t5a_quot", last_q, 16'hFFF2);
        chk("t5a_rem",  last_r, 8'hFE);
        do_op(16'd100, -8'sd7, LAT);
        chk("t5b_quot", last_q, 16'hFFF2);
        chk("t5b_rem",  last_r, 8'h02);
        do_op(16'h8000, 8'hFF, LAT);
        chk("t5c_quot", last_q, 16'h8000);
        chk("t5c_rem",  last_r, 8'h00);
`endif

        // result held while out_rdy is low; queued op waits for the handshake
        bus.in0_data = 16'd5000;
        bus.in1_data = 8'd33;
        bus.div_vld  = 1'b1;
        @(posedge clk); #1;
        bus.div_vld = 1'b0;
        lat = 0;
        while (!bus.out_vld && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t4_lat", lat, LAT);
        q0 = bus.out_quot;
        r0 = bus.out_rem;
        bus.in0_data = 16'd777;
        bus.in1_data = 8'd10;
        bus.div_vld  = 1'b1;
        @(posedge clk); #1;
        bus.div_vld = 1'b0;
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!bus.out_vld || bus.out_quot !== q0 || bus.out_rem !== r0)
                bad++;
        end
        chk("t4_stable", bad, 0);
        chk("t4_first", {q0, r0}, {16'd151, 8'd17});
        chk("t4_busy", bus.div_busy, 1);
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;
        chk("t4_vld_drop", bus.out_vld, 0);
        lat = 0;
        while (!bus.out_vld && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t4_next_lat", lat, LAT - 1);
        chk("t4_next_res", {bus.out_quot, bus.out_rem}, {16'd77, 8'd7});
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;

        // back-to-back stream filling the FIFO, scoreboard checks order
        mon_en      = 1'b1;
        bus.out_rdy = 1'b1;
        acc         = 0;
        saw_full    = 1'b0;
        for (int cyc = 0; cyc < 3000 && acc < 20; cyc++) begin
            a = DVD_W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : DVS_W'($urandom);
            bus.in0_data = a;
            bus.in1_data = b;
            bus.div_vld  = 1'b1;
            @(negedge clk);
            if (bus.div_rdy) begin
                exp_q.push_back(model(a, b));
                acc++;
            end else begin
                saw_full = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.div_vld = 1'b0;
        chk("t3_acc",  acc, 20);
        chk("t3_full", saw_full, 1);
        for (int k = 0; k < 2000 && !last_hs; k++) @(negedge clk);
        chk("t3_done", last_hs, 1);
        @(posedge clk); #1;
        chk("t3_busy_end", bus.div_busy, 0);
        chk("t3_count", n_res, 20);
        mon_en      = 1'b0;
        bus.out_rdy = 1'b0;

        // reset in CALC with requests queued discards everything
        for (int i = 0; i < 4; i++) begin
            bus.in0_data = DVD_W'(1000 + i);
            bus.in1_data = 8'd3;
            bus.div_vld  = 1'b1;
            @(posedge clk); #1;
        end
        bus.div_vld = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_vld",  bus.out_vld, 0);
        chk("t6_rdy",  bus.div_rdy, 1);
        chk("t6_busy", bus.div_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_rdy = 1'b1;
        stale = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_vld || bus.div_busy) stale++;
        end
        bus.out_rdy = 1'b0;
        chk("t6_stale", stale, 0);
        do_op(16'd50, 8'd5, LAT);
        chk("t6_quot", last_q, 16'd10);
        chk("t6_rem",  last_r, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
